ram_cmd_burst: RTL and testbench
================================

# ram_cmd_burst

Parametrised single-port command RAM: the next generation of the SPI-slave-side RAM. It decodes a command word of {2-bit opcode, DATA_W-bit payload} arriving with `rx_valid`, and maintains independent write and read address pointers. It adds three things: optional post-increment auto-addressing for burst transfers, a `tx_valid`/`tx_ready` hold handshake on the read path, and sticky error flags for out-of-range addresses and read overruns. It sits between the SPI slave's receive/transmit shifters and the rest of the design.

## Interface
Parameters:
- `DATA_W`, 8, memory word width; also the command payload width. Must be ≥ `ADDR_W`.
- `ADDR_W`, 8, address pointer width.
- `MEM_DEPTH`, 256, number of words. Must be ≤ 2**`ADDR_W`; need not be a power of two.
- `AUTO_INC`, 1, when 1, `wr_addr` post-increments after each write-data command and `rd_addr` after each accepted read command.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  command strobe; one command accepted per cycle when high.
- `rx_data`  in  DATA_W+2  [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload.
- `tx_ready`  in  1  consumer accepts `tx_data` when high with `tx_valid`.
- `tx_valid`  out  1  read data available; held until taken.
- `tx_data`  out  DATA_W  read data.
- `addr_err`  out  1  sticky: a set-address payload was ≥ `MEM_DEPTH`.
- `overrun`  out  1  sticky: a read command was dropped because the output was still held.

## Operation
- Opcodes, acted on only when `rx_valid`=1:
  - 00 SET_WR: if payload[ADDR_W-1:0] < `MEM_DEPTH`, then `wr_addr` ← that value. Otherwise the command is ignored and `addr_err` ← 1. Payload bits above `ADDR_W` are ignored.
  - 01 WRITE: `mem[wr_addr]` ← payload. If `AUTO_INC`, `wr_addr` advances.
  - 10 SET_RD: same range check as SET_WR, applied to `rd_addr`.
  - 11 READ: accepted when `tx_valid`=0, or when `tx_valid`=1 and `tx_ready`=1 in the same cycle.
    - When accepted: `tx_data` ← `mem[rd_addr]`, `tx_valid` ← 1, and `rd_addr` advances if `AUTO_INC`.
    - When not accepted: the command is dropped, `rd_addr` is unchanged, and `overrun` ← 1.
- Pointer advance: `MEM_DEPTH`-1 wraps to 0. Wrap occurs at `MEM_DEPTH`, not at 2**`ADDR_W`.
- Non-read commands execute regardless of output state. `tx_valid`/`tx_data` are untouched by them.
- Output drain: when `tx_valid`=1, `tx_ready`=1 and no accepted READ in that cycle, `tx_valid` ← 0. `tx_data` keeps its last value.
- Memory contents are not reset and are undefined until written. Reset does not clear the array.
- Reset (`rst`=1 at an edge; overrides any command in that cycle):
  - `wr_addr`, `rd_addr` ← 0.
  - `tx_valid` ← 0, `tx_data` ← 0.
  - `addr_err`, `overrun` ← 0.
  - Memory is retained.
- The error flags clear only on reset.

## Timing
- Every command takes effect at the rising edge where `rx_valid`=1.
- WRITE → READ of the same address on the next cycle returns the new data. No write-to-read hazard exists, since only one command is accepted per cycle.
- READ latency is 1 cycle: `tx_valid`/`tx_data` are registered and visible after the edge that accepted the READ.
- Back-to-back READs with `tx_ready` held at 1 give one word per cycle, and `tx_valid` stays high continuously.
- `tx_data` is stable whenever `tx_valid`=1 and `tx_ready`=0.
- `tx_ready` is ignored while `tx_valid`=0.
- `rst` asserted mid-burst: pointers return to 0 on that edge, and a held output word is discarded.

## Test plan
- Reset, then SET_WR 0x10, WRITE 0xA5, WRITE 0x5A, SET_RD 0x10, READ, READ with `tx_ready`=1 → `tx_data` = 0xA5 then 0x5A on consecutive cycles, `tx_valid` high for 2 cycles, then 0.
- `MEM_DEPTH`=200, SET_WR 199, WRITE 0x11, WRITE 0x22 → `mem[199]`=0x11, `mem[0]`=0x22. SET_WR 200 → `addr_err`=1 and `wr_addr` stays 1.
- `tx_ready`=0: READ from addr 3 (holding 0x33), then READ again → `tx_data` holds 0x33, `overrun`=1, `rd_addr`=4. Raise `tx_ready` with READ in the same cycle → `tx_data`=`mem[4]`, `tx_valid` stays 1.
- `AUTO_INC`=0: SET_RD 7, three READs with `tx_ready`=1 → `mem[7]` returned three times. Writes always land at the same address.
- Write 0x77 to addr 2, then assert `rst` while `tx_valid`=1 → all outputs and flags 0 next cycle. SET_RD 2, READ → 0x77, showing memory is retained.

Source files
------------

// File: rtl/ram_cmd_burst_if.sv
// Command/response bundle between the SPI slave shifters and ram_cmd_burst.
// The master side issues commands and consumes read data; the slave side is the RAM.
interface ram_cmd_burst_if #(
    parameter int DATA_W = 8
);
    logic              rx_valid;
    logic [DATA_W+1:0] rx_data;
    logic              tx_ready;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              addr_err;
    logic              overrun;

    modport master (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, addr_err, overrun
    );

    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, addr_err, overrun
    );
endinterface

// File: rtl/ram_cmd_burst.sv
// Single-port command RAM with independent write/read pointers, optional burst
// auto-increment, a held read output with ready handshake, and sticky error flags.
module ram_cmd_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic           clk,
    input  logic           rst,
    ram_cmd_burst_if.slave bus
);

    typedef enum logic [1:0] {
        OP_SET_WR = 2'b00,
        OP_WRITE  = 2'b01,
        OP_SET_RD = 2'b10,
        OP_READ   = 2'b11
    } opcode_e;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(MEM_DEPTH - 1);
    localparam bit                INC_C   = (AUTO_INC != 0);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_tx_valid;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_addr_err;
    logic              r_overrun;

    opcode_e           w_op;
    logic [DATA_W-1:0] w_payload;
    logic [ADDR_W-1:0] w_addr_arg;
    logic              w_addr_ok;
    logic              w_is_read;
    logic              w_rd_accept;
    logic              w_do_write;
    logic [ADDR_W-1:0] w_wr_next;
    logic [ADDR_W-1:0] w_rd_next;

    assign w_op       = opcode_e'(bus.rx_data[DATA_W+1:DATA_W]);
    assign w_payload  = bus.rx_data[DATA_W-1:0];
    assign w_addr_arg = w_payload[ADDR_W-1:0];
    assign w_addr_ok  = ({1'b0, w_addr_arg} < DEPTH_C);

    // A READ only takes the output slot if it is empty or being vacated this cycle.
    assign w_is_read   = bus.rx_valid && (w_op == OP_READ);
    assign w_rd_accept = w_is_read && (!r_tx_valid || bus.tx_ready);
    assign w_do_write  = bus.rx_valid && (w_op == OP_WRITE);

    // Pointers wrap at the last implemented word, not at the pointer's natural width.
    assign w_wr_next = (r_wr_addr == LAST_C) ? '0 : r_wr_addr + ADDR_W'(1);
    assign w_rd_next = (r_rd_addr == LAST_C) ? '0 : r_rd_addr + ADDR_W'(1);

    // NOTE: the array has no reset branch so it maps onto plain RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && w_do_write) begin
            r_mem[r_wr_addr] <= w_payload;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_addr_err <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (bus.rx_valid) begin
                case (w_op)
                    OP_SET_WR: begin
                        if (w_addr_ok) r_wr_addr  <= w_addr_arg;
                        else           r_addr_err <= 1'b1;
                    end
                    OP_WRITE: begin
                        if (INC_C) r_wr_addr <= w_wr_next;
                    end
                    OP_SET_RD: begin
                        if (w_addr_ok) r_rd_addr  <= w_addr_arg;
                        else           r_addr_err <= 1'b1;
                    end
                    OP_READ: begin
                        if (w_rd_accept) begin
                            r_tx_data  <= r_mem[r_rd_addr];
                            r_tx_valid <= 1'b1;
                            if (INC_C) r_rd_addr <= w_rd_next;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (!w_rd_accept && r_tx_valid && bus.tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign bus.addr_err = r_addr_err;
    assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_ram_cmd_burst.sv
// Bench for ram_cmd_burst: directed vector table, hand sequences for AUTO_INC=0,
// then randomized commands on two configurations against an abstract model.
module tb_ram_cmd_burst;

    localparam logic [1:0] SW = 2'b00, WR = 2'b01, SR = 2'b10, RD = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_cmd_burst_if #(.DATA_W(8)) bus_a ();
    ram_cmd_burst_if #(.DATA_W(8)) bus_b ();

    // Instance A: non-power-of-two depth with bursts; instance B: full depth, fixed addressing.
    ram_cmd_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );
    ram_cmd_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [1:0] op,
                         input logic [7:0] pay, input logic rdy);
        if (k == 0) begin
            bus_a.rx_valid = v; bus_a.rx_data = {op, pay}; bus_a.tx_ready = rdy;
        end else begin
            bus_b.rx_valid = v; bus_b.rx_data = {op, pay}; bus_b.tx_ready = rdy;
        end
    endtask

    task automatic check_outs(input int k, input string tag, input logic tv,
                              input logic [7:0] td, input bit chk_td,
                              input logic ae, input logic ov);
        logic       a_tv, a_ae, a_ov;
        logic [7:0] a_td;
        a_tv = (k == 0) ? bus_a.tx_valid : bus_b.tx_valid;
        a_td = (k == 0) ? bus_a.tx_data  : bus_b.tx_data;
        a_ae = (k == 0) ? bus_a.addr_err : bus_b.addr_err;
        a_ov = (k == 0) ? bus_a.overrun  : bus_b.overrun;
        check({tag, " tx_valid"}, 32'(a_tv), 32'(tv));
        if (chk_td) check({tag, " tx_data"}, 32'(a_td), 32'(td));
        check({tag, " addr_err"}, 32'(a_ae), 32'(ae));
        check({tag, " overrun"}, 32'(a_ov), 32'(ov));
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] op;
        logic [7:0] pay;
        logic       rdy;
        logic       tv;
        logic [7:0] td;
        logic       ae;
        logic       ov;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] op,
                                input logic [7:0] pay, input logic rdy, input logic tv,
                                input logic [7:0] td, input logic ae, input logic ov);
        vec_t x;
        x.r = r; x.v = v; x.op = op; x.pay = pay; x.rdy = rdy;
        x.tv = tv; x.td = td; x.ae = ae; x.ov = ov;
        return x;
    endfunction

    // Reference model: per-instance pointers as plain integers, memory as arrays,
    // with a "known" bit so reads of never-written words are not compared.
    typedef struct {
        int         wr;
        int         rd;
        bit         tv;
        logic [7:0] td;
        bit         tk;
        bit         ae;
        bit         ov;
    } mst_t;

    mst_t       ms [2];
    logic [7:0] mm [2][256];
    bit         mkn[2][256];
    int         depth_of[2] = '{200, 256};
    bit         inc_of[2]   = '{1'b1, 1'b0};

    task automatic model_step(input int k, input bit r, input bit v, input logic [1:0] op,
                              input logic [7:0] pay, input bit rdy);
        bit took;
        took = 1'b0;
        if (r) begin
            ms[k].wr = 0; ms[k].rd = 0; ms[k].tv = 1'b0; ms[k].td = 8'h00;
            ms[k].tk = 1'b1; ms[k].ae = 1'b0; ms[k].ov = 1'b0;
            return;
        end
        if (v) begin
            case (op)
                SW: if (int'(pay) < depth_of[k]) ms[k].wr = int'(pay); else ms[k].ae = 1'b1;
                WR: begin
                    mm[k][ms[k].wr]  = pay;
                    mkn[k][ms[k].wr] = 1'b1;
                    if (inc_of[k]) ms[k].wr = (ms[k].wr + 1) % depth_of[k];
                end
                SR: if (int'(pay) < depth_of[k]) ms[k].rd = int'(pay); else ms[k].ae = 1'b1;
                default: begin
                    if (!ms[k].tv || rdy) begin
                        ms[k].td = mm[k][ms[k].rd];
                        ms[k].tk = mkn[k][ms[k].rd];
                        ms[k].tv = 1'b1;
                        took     = 1'b1;
                        if (inc_of[k]) ms[k].rd = (ms[k].rd + 1) % depth_of[k];
                    end else begin
                        ms[k].ov = 1'b1;
                    end
                end
            endcase
        end
        if (!took && ms[k].tv && rdy) ms[k].tv = 1'b0;
    endtask

    task automatic b_step(input string tag, input logic v, input logic [1:0] op,
                          input logic [7:0] pay, input logic rdy, input logic tv,
                          input logic [7:0] td, input logic ov);
        drive(1, v, op, pay, rdy);
        @(posedge clk);
        #1;
        check_outs(1, tag, tv, td, 1'b1, 1'b0, ov);
    endtask

    vec_t vecs[$];

    initial begin
        logic       rv  [2];
        logic [1:0] rop [2];
        logic [7:0] rpay[2];
        logic       rrdy[2];
        logic       rr;
        int         pick;

        //            rst  v   op  pay    rdy  tv  td     ae  ov
        vecs.push_back(mk(1, 0, SW, 8'h00, 0,  0, 8'h00, 0, 0)); // reset state
        vecs.push_back(mk(0, 1, SW, 8'h10, 0,  0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, WR, 8'hA5, 0,  0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, WR, 8'h5A, 0,  0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, SR, 8'h10, 0,  0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, RD, 8'h00, 1,  1, 8'hA5, 0, 0)); // burst read
        vecs.push_back(mk(0, 1, RD, 8'h00, 1,  1, 8'h5A, 0, 0));
        vecs.push_back(mk(0, 0, SW, 8'h00, 1,  0, 8'h5A, 0, 0)); // drain, data kept
        vecs.push_back(mk(0, 0, SW, 8'h00, 1,  0, 8'h5A, 0, 0)); // ready ignored when idle
        vecs.push_back(mk(0, 1, SW, 8'hC7, 0,  0, 8'h5A, 0, 0)); // wr=199
        vecs.push_back(mk(0, 1, WR, 8'h11, 0,  0, 8'h5A, 0, 0)); // mem[199], wrap
        vecs.push_back(mk(0, 1, WR, 8'h22, 0,  0, 8'h5A, 0, 0)); // mem[0]
        vecs.push_back(mk(0, 1, SW, 8'hC8, 0,  0, 8'h5A, 1, 0)); // out of range
        vecs.push_back(mk(0, 1, WR, 8'h33, 0,  0, 8'h5A, 1, 0)); // lands at 1
        vecs.push_back(mk(0, 1, SR, 8'hC7, 0,  0, 8'h5A, 1, 0));
        vecs.push_back(mk(0, 1, RD, 8'h00, 0,  1, 8'h11, 1, 0));
        vecs.push_back(mk(0, 1, RD, 8'h00, 1,  1, 8'h22, 1, 0)); // rd wrapped to 0
        vecs.push_back(mk(0, 1, RD, 8'h00, 1,  1, 8'h33, 1, 0)); // wr stayed at 1
        vecs.push_back(mk(0, 0, SW, 8'h00, 1,  0, 8'h33, 1, 0));
        vecs.push_back(mk(0, 1, SW, 8'h03, 0,  0, 8'h33, 1, 0));
        vecs.push_back(mk(0, 1, WR, 8'h33, 0,  0, 8'h33, 1, 0));
        vecs.push_back(mk(0, 1, WR, 8'h44, 0,  0, 8'h33, 1, 0));
        vecs.push_back(mk(0, 1, SR, 8'h03, 0,  0, 8'h33, 1, 0));
        vecs.push_back(mk(0, 1, RD, 8'h00, 0,  1, 8'h33, 1, 0));
        vecs.push_back(mk(0, 1, RD, 8'h00, 0,  1, 8'h33, 1, 1)); // dropped: overrun
        vecs.push_back(mk(0, 0, SW, 8'h00, 0,  1, 8'h33, 1, 1)); // held stable
        vecs.push_back(mk(0, 1, RD, 8'h00, 1,  1, 8'h44, 1, 1)); // rd_addr was 4
        vecs.push_back(mk(0, 0, SW, 8'h00, 0,  1, 8'h44, 1, 1));
        vecs.push_back(mk(0, 0, SW, 8'h00, 1,  0, 8'h44, 1, 1));
        vecs.push_back(mk(0, 1, SW, 8'h02, 0,  0, 8'h44, 1, 1));
        vecs.push_back(mk(0, 1, WR, 8'h77, 0,  0, 8'h44, 1, 1));
        vecs.push_back(mk(0, 1, SR, 8'h02, 0,  0, 8'h44, 1, 1));
        vecs.push_back(mk(0, 1, RD, 8'h00, 0,  1, 8'h77, 1, 1));
        vecs.push_back(mk(1, 1, RD, 8'h00, 0,  0, 8'h00, 0, 0)); // reset mid-burst
        vecs.push_back(mk(0, 1, SR, 8'h02, 0,  0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, RD, 8'h00, 0,  1, 8'h77, 0, 0)); // memory retained
        vecs.push_back(mk(0, 0, SW, 8'h00, 1,  0, 8'h77, 0, 0));

        drive(0, 1'b0, SW, 8'h00, 1'b0);
        drive(1, 1'b0, SW, 8'h00, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].r;
            drive(0, vecs[i].v, vecs[i].op, vecs[i].pay, vecs[i].rdy);
            @(posedge clk);
            #1;
            check_outs(0, $sformatf("vec%0d", i), vecs[i].tv, vecs[i].td, 1'b1,
                       vecs[i].ae, vecs[i].ov);
        end
        rst = 1'b0;
        drive(0, 1'b0, SW, 8'h00, 1'b0);

        // Fixed addressing: writes overwrite one word, reads repeat it.
        b_step("b set_wr",  1, SW, 8'h07, 0, 0, 8'h00, 0);
        b_step("b wr70",    1, WR, 8'h70, 0, 0, 8'h00, 0);
        b_step("b wr71",    1, WR, 8'h71, 0, 0, 8'h00, 0);
        b_step("b set_rd",  1, SR, 8'h07, 0, 0, 8'h00, 0);
        b_step("b rd1",     1, RD, 8'h00, 1, 1, 8'h71, 0);
        b_step("b rd2",     1, RD, 8'h00, 1, 1, 8'h71, 0);
        b_step("b rd3",     1, RD, 8'h00, 1, 1, 8'h71, 0);
        b_step("b wr72",    1, WR, 8'h72, 1, 0, 8'h71, 0);
        b_step("b rd4",     1, RD, 8'h00, 1, 1, 8'h72, 0);
        b_step("b idle",    0, SW, 8'h00, 1, 0, 8'h72, 0);
        b_step("b set_wff", 1, SW, 8'hFF, 0, 0, 8'h72, 0);
        b_step("b wrEE",    1, WR, 8'hEE, 0, 0, 8'h72, 0);
        b_step("b set_rff", 1, SR, 8'hFF, 0, 0, 8'h72, 0);
        b_step("b rdff",    1, RD, 8'h00, 0, 1, 8'hEE, 0);
        b_step("b ovr",     1, RD, 8'h00, 0, 1, 8'hEE, 1);
        drive(1, 1'b0, SW, 8'h00, 1'b0);

        // Random phase: both configurations, model starts after a reset with memory unknown.
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 256; a++) mkn[k][a] = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, 1'b1, 1'b0, SW, 8'h00, 1'b0);
        #1;
        rst = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            rr = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                rv[k]  = ($urandom_range(0, 3) != 0);
                rop[k] = 2'($urandom_range(0, 3));
                pick   = $urandom_range(0, 15);
                if (pick == 0)      rpay[k] = 8'(depth_of[k] - 1);
                else if (pick == 1) rpay[k] = 8'($urandom_range(0, 255));
                else                rpay[k] = 8'($urandom_range(0, depth_of[k] - 1));
                rrdy[k] = ($urandom_range(0, 1) == 1);
                drive(k, rv[k], rop[k], rpay[k], rrdy[k]);
            end
            rst = rr;
            @(posedge clk);
            for (int k = 0; k < 2; k++) model_step(k, rr, rv[k], rop[k], rpay[k], rrdy[k]);
            #1;
            for (int k = 0; k < 2; k++) begin
                check_outs(k, $sformatf("rand%s c%0d", (k == 0) ? "A" : "B", c),
                           ms[k].tv, ms[k].td, ms[k].tk, ms[k].ae, ms[k].ov);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
